// File: rtl/bsg_fifo_1rw_sync_ctrl.sv
// bsg_fifo_1rw_sync_ctrl
//   Ready/valid FIFO controller in front of a single-port synchronous RAM.
//   Each cycle the one RAM port is given to either an enqueue write or a
//   head-prefetch read (the read wins). A one-entry output register holds
//   the FIFO head, so total capacity is els_p + 1.
//
//   Optional feature macro: BSG_FIFO_1RW_SYNC_CTRL_BYPASS_EN
//     defined   - an enqueue into a completely empty FIFO goes straight to
//                 the output register without touching the RAM.
//     undefined - every enqueue is written to the RAM first.

module bsg_fifo_1rw_sync_ctrl #(
    parameter int width_p       = -1,
    parameter int els_p         = -1,
    parameter int addr_width_lp = (els_p <= 1) ? 1 : $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     v_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     ready_o,

    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,

    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    input  logic [width_p-1:0]       mem_data_i
);

    // count must be able to hold els_p itself, hence clog2(els_p + 1)
    localparam int count_width_lp = (els_p < 1) ? 1 : $clog2(els_p + 1);
    localparam logic [addr_width_lp-1:0]  last_addr_lp  = addr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

    logic [addr_width_lp-1:0]  wptr;
    logic [addr_width_lp-1:0]  rptr;
    logic [count_width_lp-1:0] count;
    logic                      rd_pend;
    logic                      out_v;
    logic [width_p-1:0]        out_data;

    logic count_zero;
    logic count_full;
    logic out_free;
    logic rd_go;
    logic enq;
    logic bypass;
    logic wr;

    // Port arbitration: a prefetch read wins whenever the output register
    // is (or is about to become) free and no read is already in flight.
    // NOTE: every signal driven here gets a value on every path (here by
    // continuous-style defaults at the top), so no latch can be inferred.
    always_comb begin
        count_zero = (count == '0);
        count_full = (count == full_count_lp);
        out_free   = ~out_v | yumi_i;
        rd_go      = ~count_zero & ~rd_pend & out_free;
        ready_o    = ~reset_i & ~count_full & ~rd_go;
        enq        = v_i & ready_o;
`ifdef BSG_FIFO_1RW_SYNC_CTRL_BYPASS_EN
        bypass     = enq & count_zero & ~rd_pend & out_free;
`else
        bypass     = 1'b0;
`endif
        wr         = enq & ~bypass;

        mem_v_o    = wr | rd_go;
        mem_w_o    = wr;
        mem_addr_o = rd_go ? rptr : wptr;
        mem_data_o = data_i;
    end

    // Write and read pointers, wrapping at els_p-1 (depth need not be 2^n).
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr)
                wptr <= (wptr == last_addr_lp) ? '0 : wptr + addr_width_lp'(1);
            if (rd_go)
                rptr <= (rptr == last_addr_lp) ? '0 : rptr + addr_width_lp'(1);
        end
    end

    // Entries held in the RAM that have not been read out yet. A write and
    // a read never coincide because ready_o is low on read cycles.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (wr) begin
            count <= count + count_width_lp'(1);
        end else if (rd_go) begin
            count <= count - count_width_lp'(1);
        end
    end

    // Read-in-flight flag; clearing it on reset drops any returning data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_go;
        end
    end

    // Output register: refilled from the RAM or the bypass, emptied by yumi.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_v    <= 1'b0;
            out_data <= '0;
        end else if (rd_pend) begin
            out_v    <= 1'b1;
            out_data <= mem_data_i;
        end else if (bypass) begin
            out_v    <= 1'b1;
            out_data <= data_i;
        end else if (yumi_i) begin
            out_v    <= 1'b0;
        end
    end

    assign v_o    = out_v;
    assign data_o = out_data;

endmodule

// File: tb/tb_bsg_fifo_1rw_sync_ctrl.sv
// Testbench for bsg_fifo_1rw_sync_ctrl: instance a (els_p=4) and
// instance b (els_p=3), each backed by a behavioural 1rw sync RAM.
// Expectations follow BSG_FIFO_1RW_SYNC_CTRL_BYPASS_EN when defined.

module tb_bsg_fifo_1rw_sync_ctrl;

    logic clk = 1'b0;
    logic reset_i;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // instance a signals
    logic       a_v, a_ready, a_vo, a_yumi, a_mem_v, a_mem_w;
    logic [7:0] a_data, a_dout, a_mem_wdata, a_mem_rdata;
    logic [1:0] a_mem_addr;
    logic [7:0] a_ram [4];

    // instance b signals
    logic       b_v, b_ready, b_vo, b_yumi, b_mem_v, b_mem_w;
    logic [7:0] b_data, b_dout, b_mem_wdata, b_mem_rdata;
    logic [1:0] b_mem_addr;
    logic [7:0] b_ram [3];

    bsg_fifo_1rw_sync_ctrl #(.width_p(8), .els_p(4)) dut_a (
        .clk_i(clk), .reset_i(reset_i),
        .v_i(a_v), .data_i(a_data), .ready_o(a_ready),
        .v_o(a_vo), .data_o(a_dout), .yumi_i(a_yumi),
        .mem_v_o(a_mem_v), .mem_w_o(a_mem_w), .mem_addr_o(a_mem_addr),
        .mem_data_o(a_mem_wdata), .mem_data_i(a_mem_rdata)
    );

    bsg_fifo_1rw_sync_ctrl #(.width_p(8), .els_p(3)) dut_b (
        .clk_i(clk), .reset_i(reset_i),
        .v_i(b_v), .data_i(b_data), .ready_o(b_ready),
        .v_o(b_vo), .data_o(b_dout), .yumi_i(b_yumi),
        .mem_v_o(b_mem_v), .mem_w_o(b_mem_w), .mem_addr_o(b_mem_addr),
        .mem_data_o(b_mem_wdata), .mem_data_i(b_mem_rdata)
    );

    // behavioural single-port synchronous RAMs
    always @(posedge clk) begin
        if (a_mem_v) begin
            if (a_mem_w) a_ram[a_mem_addr] <= a_mem_wdata;
            else         a_mem_rdata       <= a_ram[a_mem_addr];
        end
        if (b_mem_v) begin
            if (b_mem_w) b_ram[b_mem_addr] <= b_mem_wdata;
            else         b_mem_rdata       <= b_ram[b_mem_addr];
        end
    end

    // one cycle on instance a: drive at negedge, observe 1 time unit later
    task automatic a_cycle(input logic v, input logic [7:0] d, input logic auto_yumi,
                           output logic acc, output logic pop, output logic [7:0] pd);
        @(negedge clk);
        a_yumi = auto_yumi & a_vo;
        a_v    = v;
        a_data = d;
        #1;
        acc = a_v & a_ready;
        pop = a_yumi;
        pd  = a_dout;
    endtask

    task automatic b_cycle(input logic v, input logic [7:0] d, input logic auto_yumi,
                           output logic acc, output logic pop, output logic [7:0] pd);
        @(negedge clk);
        b_yumi = auto_yumi & b_vo;
        b_v    = v;
        b_data = d;
        #1;
        acc = b_v & b_ready;
        pop = b_yumi;
        pd  = b_dout;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        a_v = 1'b1; a_data = 8'h11; a_yumi = 1'b0;
        b_v = 1'b1; b_data = 8'h22; b_yumi = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (a_vo !== 1'b0) begin n_bad++; $display("FAIL reset_v_o: got %b want 0", a_vo); end
        n_cmp++;
        if (a_dout !== 8'h00) begin n_bad++; $display("FAIL reset_data_o: got %h want 00", a_dout); end
        n_cmp++;
        if (a_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_o: got %b want 0", a_ready); end
        n_cmp++;
        if (a_mem_v !== 1'b0 || b_mem_v !== 1'b0) begin
            n_bad++; $display("FAIL reset_mem_v_o: got a=%b b=%b want 0", a_mem_v, b_mem_v);
        end
        @(negedge clk);
        reset_i = 1'b0;
        a_v = 1'b0;
        b_v = 1'b0;
        #1;
        n_cmp++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_bad++; $display("FAIL idle_ready_o: got a=%b b=%b want 1", a_ready, b_ready);
        end
        n_cmp++;
        if (a_vo !== 1'b0 || a_mem_v !== 1'b0) begin
            n_bad++; $display("FAIL idle_quiet: got v_o=%b mem_v=%b want 0 0", a_vo, a_mem_v);
        end
    endtask

    task automatic test_single();
        logic acc, pop;
        logic [7:0] pd;
        a_cycle(1'b1, 8'hA5, 1'b0, acc, pop, pd);
        n_cmp++;
        if (acc !== 1'b1) begin n_bad++; $display("FAIL single_accept: got %b want 1", acc); end
`ifdef BSG_FIFO_1RW_SYNC_CTRL_BYPASS_EN
        n_cmp++;
        if (a_mem_v !== 1'b0) begin n_bad++; $display("FAIL single_no_ram: got mem_v=%b want 0", a_mem_v); end
        a_cycle(1'b0, 8'h00, 1'b0, acc, pop, pd);
        n_cmp++;
        if (a_vo !== 1'b1 || a_dout !== 8'hA5) begin
            n_bad++; $display("FAIL single_bypass_out: got v=%b d=%h want 1 a5", a_vo, a_dout);
        end
        n_cmp++;
        if (a_mem_v !== 1'b0) begin n_bad++; $display("FAIL single_no_read: got mem_v=%b want 0", a_mem_v); end
`else
        n_cmp++;
        if ({a_mem_v, a_mem_w, a_mem_addr} !== 4'b1100) begin
            n_bad++; $display("FAIL single_write: got v=%b w=%b addr=%0d want 1 1 0", a_mem_v, a_mem_w, a_mem_addr);
        end
        a_cycle(1'b0, 8'h00, 1'b0, acc, pop, pd);
        n_cmp++;
        if ({a_mem_v, a_mem_w, a_mem_addr} !== 4'b1000 || a_vo !== 1'b0) begin
            n_bad++; $display("FAIL single_read: got v=%b w=%b addr=%0d v_o=%b want 1 0 0 0",
                              a_mem_v, a_mem_w, a_mem_addr, a_vo);
        end
        a_cycle(1'b0, 8'h00, 1'b0, acc, pop, pd);
        n_cmp++;
        if (a_vo !== 1'b0 || a_mem_v !== 1'b0) begin
            n_bad++; $display("FAIL single_t2: got v_o=%b mem_v=%b want 0 0", a_vo, a_mem_v);
        end
        a_cycle(1'b0, 8'h00, 1'b0, acc, pop, pd);
        n_cmp++;
        if (a_vo !== 1'b1 || a_dout !== 8'hA5) begin
            n_bad++; $display("FAIL single_t3_out: got v=%b d=%h want 1 a5", a_vo, a_dout);
        end
`endif
        a_cycle(1'b0, 8'h00, 1'b1, acc, pop, pd);
        a_cycle(1'b0, 8'h00, 1'b0, acc, pop, pd);
        n_cmp++;
        if (a_vo !== 1'b0) begin n_bad++; $display("FAIL single_pop: got v_o=%b want 0", a_vo); end
    endtask

    task automatic test_fill();
        logic acc, pop;
        logic [7:0] pd;
        int n_acc = 0;
        int n_pop = 0;
        int prev  = -1;
        for (int c = 0; c < 20; c++) begin
            a_cycle(1'b1, 8'(n_acc), 1'b0, acc, pop, pd);
            if (acc) n_acc++;
        end
        n_cmp++;
        if (n_acc != 5) begin n_bad++; $display("FAIL fill_count: got %0d want 5", n_acc); end
        n_cmp++;
        if (a_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_low: got %b want 0", a_ready); end
        n_cmp++;
        if (a_vo !== 1'b1 || a_dout !== 8'h00) begin
            n_bad++; $display("FAIL fill_head: got v=%b d=%h want 1 00", a_vo, a_dout);
        end
        for (int c = 0; c < 30; c++) begin
            a_cycle(1'b0, 8'h00, 1'b1, acc, pop, pd);
            if (a_mem_v && !a_mem_w) begin
                if (prev >= 0) begin
                    n_cmp++;
                    if (int'(a_mem_addr) != (prev + 1) % 4) begin
                        n_bad++; $display("FAIL fill_rptr_wrap: got %0d want %0d", a_mem_addr, (prev + 1) % 4);
                    end
                end
                prev = int'(a_mem_addr);
            end
            if (pop) begin
                n_cmp++;
                if (pd !== 8'(n_pop)) begin n_bad++; $display("FAIL fill_order: got %h want %h", pd, 8'(n_pop)); end
                n_pop++;
            end
        end
        n_cmp++;
        if (n_pop != 5 || a_vo !== 1'b0) begin
            n_bad++; $display("FAIL fill_drain: got pops=%0d v_o=%b want 5 0", n_pop, a_vo);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, pop;
        logic [7:0] pd;
        logic [7:0] sb [$];
        logic [7:0] nxt = 8'h40;
        logic prev_w = 1'bx;
        int built = 0;
        for (int c = 0; c < 20 && built < 3; c++) begin
            a_cycle(1'b1, nxt, 1'b0, acc, pop, pd);
            if (acc) begin sb.push_back(nxt); nxt++; built++; end
        end
        n_cmp++;
        if (built != 3) begin n_bad++; $display("FAIL b2b_backlog: got %0d want 3", built); end
        for (int c = 0; c < 12; c++) begin
            a_cycle(1'b1, nxt, 1'b1, acc, pop, pd);
            n_cmp++;
            if (a_mem_v !== 1'b1 || (c > 0 && a_mem_w === prev_w)) begin
                n_bad++; $display("FAIL b2b_alternate: cycle %0d got v=%b w=%b prev_w=%b", c, a_mem_v, a_mem_w, prev_w);
            end
            n_cmp++;
            if (a_ready !== a_mem_w) begin
                n_bad++; $display("FAIL b2b_ready: cycle %0d got ready=%b want %b", c, a_ready, a_mem_w);
            end
            prev_w = a_mem_w;
            if (acc) begin sb.push_back(nxt); nxt++; end
            if (pop) begin
                n_cmp++;
                if (sb.size() == 0 || pd !== sb[0]) begin
                    n_bad++; $display("FAIL b2b_order: got %h want %h", pd, (sb.size() != 0) ? sb[0] : 8'hxx);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
        for (int c = 0; c < 30; c++) begin
            a_cycle(1'b0, 8'h00, 1'b1, acc, pop, pd);
            if (pop) begin
                n_cmp++;
                if (sb.size() == 0 || pd !== sb[0]) begin
                    n_bad++; $display("FAIL b2b_drain_order: got %h want %h", pd, (sb.size() != 0) ? sb[0] : 8'hxx);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
        n_cmp++;
        if (sb.size() != 0 || a_vo !== 1'b0) begin
            n_bad++; $display("FAIL b2b_empty: got left=%0d v_o=%b want 0 0", sb.size(), a_vo);
        end
    endtask

    task automatic test_wrap();
        logic acc, pop;
        logic [7:0] pd;
        logic [7:0] sb [$];
        int sent = 0, popped = 0, round = 0, wexp = 0, rexp = 0, n_wr = 0;
        logic filling = 1'b1;
        for (int c = 0; c < 150 && popped < 10; c++) begin
            b_cycle(filling && sent < 10, 8'h80 + 8'(sent), ~filling, acc, pop, pd);
            if (b_mem_v) begin
                n_cmp++;
                if (int'(b_mem_addr) != (b_mem_w ? wexp : rexp)) begin
                    n_bad++; $display("FAIL wrap_addr: w=%b got %0d want %0d", b_mem_w, b_mem_addr, b_mem_w ? wexp : rexp);
                end
                if (b_mem_w) begin wexp = (wexp + 1) % 3; n_wr++; end
                else rexp = (rexp + 1) % 3;
            end
            if (acc) begin sb.push_back(8'h80 + 8'(sent)); sent++; round++; end
            if (pop) begin
                n_cmp++;
                if (sb.size() == 0 || pd !== sb[0]) begin
                    n_bad++; $display("FAIL wrap_data: got %h want %h", pd, (sb.size() != 0) ? sb[0] : 8'hxx);
                end
                if (sb.size() != 0) void'(sb.pop_front());
                popped++;
            end
            if (filling && (round == 4 || sent == 10)) filling = 1'b0;
            else if (!filling && popped == sent && sent < 10) begin filling = 1'b1; round = 0; end
        end
        n_cmp++;
        if (popped != 10 || n_wr < 7) begin
            n_bad++; $display("FAIL wrap_total: got pops=%0d writes=%0d want 10 >=7", popped, n_wr);
        end
        b_v = 1'b0;
        b_yumi = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic acc, pop;
        logic [7:0] pd;
        int got = 0;
        logic seen = 1'b0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            a_cycle(1'b1, 8'h77 + 8'(got), 1'b0, acc, pop, pd);
            if (acc) got++;
        end
        repeat (4) a_cycle(1'b0, 8'h00, 1'b0, acc, pop, pd);
        n_cmp++;
        if (got != 2 || a_vo !== 1'b1) begin
            n_bad++; $display("FAIL rst_setup: got accepted=%0d v_o=%b want 2 1", got, a_vo);
        end
        a_cycle(1'b0, 8'h00, 1'b1, acc, pop, pd);
        n_cmp++;
        if (a_mem_v !== 1'b1 || a_mem_w !== 1'b0) begin
            n_bad++; $display("FAIL rst_read_issue: got v=%b w=%b want 1 0", a_mem_v, a_mem_w);
        end
        @(negedge clk);
        a_yumi = 1'b0;
        reset_i = 1'b1;
        #1;
        n_cmp++;
        if (a_vo !== 1'b0 || a_mem_v !== 1'b0) begin
            n_bad++; $display("FAIL rst_async: got v_o=%b mem_v=%b want 0 0", a_vo, a_mem_v);
        end
        @(negedge clk);
        reset_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a_cycle(1'b0, 8'h00, 1'b0, acc, pop, pd);
            n_cmp++;
            if (a_vo !== 1'b0) begin n_bad++; $display("FAIL rst_drop_inflight: cycle %0d got v_o=%b want 0", c, a_vo); end
        end
        a_cycle(1'b1, 8'h3C, 1'b0, acc, pop, pd);
        n_cmp++;
        if (acc !== 1'b1) begin n_bad++; $display("FAIL rst_reenq: got %b want 1", acc); end
        for (int c = 0; c < 6 && !seen; c++) begin
            a_cycle(1'b0, 8'h00, 1'b0, acc, pop, pd);
            if (a_vo) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || a_dout !== 8'h3C) begin
            n_bad++; $display("FAIL rst_first_out: got v=%b d=%h want 1 3c", seen, a_dout);
        end
        a_cycle(1'b0, 8'h00, 1'b1, acc, pop, pd);
        a_cycle(1'b0, 8'h00, 1'b0, acc, pop, pd);
        n_cmp++;
        if (a_vo !== 1'b0) begin n_bad++; $display("FAIL rst_only_one: got v_o=%b want 0", a_vo); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_fifo_1rw_sync_ctrl.md
# bsg_fifo_1rw_sync_ctrl

Ready/valid FIFO controller that uses a single-port synchronous RAM (`bsg_mem_1rw_sync`) as its backing store. It sits directly upstream of the RAM: it drives the RAM's `v_i`/`w_i`/`addr_i`/`data_i` and consumes its registered `data_o`. It arbitrates the one RAM access per cycle between enqueue writes and head-prefetch reads. A one-entry output register presents the FIFO head to the consumer with valid/yumi semantics.

## Interface
Parameters:
- `width_p`, -1 (must be overridden), data width.
- `els_p`, -1 (must be overridden), RAM depth; ≥2; need not be a power of two.
- `addr_width_lp`, `BSG_SAFE_CLOG2(els_p)`, RAM address width.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_i`  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- `v_i`  in  1  enqueue valid.
- `data_i`  in  width_p  enqueue data.
- `ready_o`  out  1  enqueue accepted when `v_i & ready_o`.
- `v_o`  out  1  head valid.
- `data_o`  out  width_p  head data (registered).
- `yumi_i`  in  1  consumer pops head; only legal when `v_o`.
- `mem_v_o`  out  1  RAM access enable.
- `mem_w_o`  out  1  RAM write (1) / read (0).
- `mem_addr_o`  out  addr_width_lp  RAM address.
- `mem_data_o`  out  width_p  RAM write data (= `data_i`).
- `mem_data_i`  in  width_p  RAM read data, valid the cycle after a read.

## Operation
- State: `wptr`, `rptr` (0..els_p-1, increment wraps els_p-1→0); `count` (RAM entries not yet read, width clog2(els_p+1)); `rd_pend` (read issued last cycle); `out_v`/`out_data` output register.
- `rd_go = (count != 0) & ~rd_pend & (~out_v | yumi_i)`.
- `ready_o = ~reset_i & (count != els_p) & ~rd_go` (read has priority; combinational path `yumi_i`→`ready_o` is intentional).
- `bypass = v_i & ready_o & (count == 0) & ~rd_pend & (~out_v | yumi_i)`: data goes straight into output register; no RAM access.
- Otherwise accepted enqueue: `mem_v_o=1, mem_w_o=1, mem_addr_o=wptr`; `wptr++`, `count++`.
- `rd_go`: `mem_v_o=1, mem_w_o=0, mem_addr_o=rptr`; `rptr++`, `count--`, `rd_pend<=1`.
- `rd_pend` cycle: `out_data<=mem_data_i`, `out_v<=1` (register is guaranteed empty by the `rd_go` condition).
- `yumi_i` without a refill clears `out_v`. `yumi_i` while `~v_o` is illegal; no defined behaviour.
- Capacity is `els_p+1` (RAM plus output register). `ready_o` is low when `count==els_p`.
- Simultaneous `rd_go` and `v_i`: the read issues and the enqueue stalls (`ready_o=0`) that cycle.

## Timing
- Reset (asynchronous assert): pointers, `count`, `rd_pend`, `out_v`, and `out_data` are cleared to 0. While reset is held, `v_o=0`, `data_o=0`, `ready_o=0`, and `mem_v_o=0`. First enqueue is possible in the first cycle after deassertion.
- Reset mid-operation discards all contents, including any in-flight read; `mem_data_i` is ignored next cycle.
- Latency on an empty FIFO via bypass: `v_o` is high the cycle after the enqueue.
- Latency through the RAM: read issued in cycle t, `v_o` high in cycle t+2.
- Sustained simultaneous enq/deq with a backlog in the RAM: reads and writes alternate; throughput is 1 item per 2 cycles.

## Configuration
- `BSG_FIFO_1RW_SYNC_CTRL_BYPASS_EN` defined: the bypass path is present as described above.
- Undefined: `bypass` is forced to 0. Every enqueue writes the RAM, so empty-FIFO latency is 3 cycles (write t, read t+1, `v_o` at t+3). All other rules are unchanged.

## Test plan
- Reset then idle: during and after reset `v_o=0`, `mem_v_o=0`. After deassertion `ready_o=1`.
- Single enqueue `0xA5` into empty FIFO (bypass on): `v_o=1`, `data_o=0xA5` next cycle, no RAM access. With the macro off: RAM write at addr 0, read at addr 0, `v_o` 3 cycles after the enqueue.
- Fill with els_p=4 and no yumi: 5 items accepted (1 in output register, 4 in RAM), then `ready_o=0`. Drain returns them in order 0..4 with correct wrap of `rptr`.
- Continuous `v_i` plus `yumi_i` with a backlog: `mem_w_o` alternates 1/0 each cycle, `ready_o` low on read cycles, and output order is preserved.
- Pointer wrap with els_p=3: enqueue and dequeue 10 items. Addresses cycle 0,1,2,0…, and data matches a reference queue.
- Assert `reset_i` the cycle after a read issue: `v_o` stays 0, the returning `mem_data_i` is dropped, and a subsequent enqueue of `0x3C` emerges first.
